// File: rtl/fun_feeder.sv
// fun_feeder: buffers operand pairs in a small FIFO and drives the fun block one
// job at a time, presenting each result on a valid/ready output.
module fun_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [7:0]             a_i,
  input  logic [7:0]             b_i,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o,
  output logic [7:0]             a_bo,
  output logic [7:0]             b_bo,
  output logic                   start_o,
  input  logic                   busy_i,
  input  logic [7:0]             res_i,
  output logic [7:0]             y_bo,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_r;
  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          pop_s;
  logic          push_ok_s;
  logic [CW-1:0] count_nxt_s;
  logic [15:0]   head_s;

  // Pop/push decisions and next occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop_s       = 1'b0;
    push_ok_s   = 1'b0;
    count_nxt_s = count_o;
    head_s      = mem_r[rd_ptr_r];
    if ((state_r == IDLE) && (count_o != {CW{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    push_ok_s = push_i && ((count_o < CNT_FULL) || pop_s);
    if (push_ok_s && !pop_s) begin
      count_nxt_s = count_o + CNT_ONE;
    end else if (!push_ok_s && pop_s) begin
      count_nxt_s = count_o - CNT_ONE;
    end else begin
      count_nxt_s = count_o;
    end
  end

  // FIFO storage, pointers, occupancy, full flag and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_o  <= {CW{1'b0}};
      full_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {a_i, b_i};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_o <= count_nxt_s;
      full_o  <= (count_nxt_s == CNT_FULL);
      if (push_i && !push_ok_s) begin
        ovf_o <= 1'b1;
      end
    end
  end

  // Job sequencer: dispatch one entry, wait for fun, hold the result until taken.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      start_o <= 1'b0;
      a_bo    <= 8'h00;
      b_bo    <= 8'h00;
      y_bo    <= 8'h00;
      valid_o <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            a_bo    <= head_s[15:8];
            b_bo    <= head_s[7:0];
            start_o <= 1'b1;
            state_r <= START;
          end
        end
        START: begin
          start_o <= 1'b0;
          state_r <= WAIT;
        end
        // busy_i is first looked at here, one edge after fun has raised it
        WAIT: begin
          if (!busy_i) begin
            y_bo    <= res_i;
            valid_o <= 1'b1;
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          start_o <= 1'b0;
          valid_o <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fun_feeder.sv
// Bench for fun_feeder: behavioural fun model, transaction-level reference model,
// and a scoreboard checked by an independent output monitor.
module tb_fun_feeder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          push_i = 1'b0;
  logic [7:0]    a_i = 8'h00;
  logic [7:0]    b_i = 8'h00;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          ovf_o;
  logic [7:0]    a_bo;
  logic [7:0]    b_bo;
  logic          start_o;
  logic          busy_i = 1'b0;
  logic [7:0]    res_i = 8'h00;
  logic [7:0]    y_bo;
  logic          valid_o;
  logic          ready_i = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fun_feeder #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .a_i(a_i), .b_i(b_i),
    .full_o(full_o), .count_o(count_o), .ovf_o(ovf_o),
    .a_bo(a_bo), .b_bo(b_bo), .start_o(start_o), .busy_i(busy_i), .res_i(res_i),
    .y_bo(y_bo), .valid_o(valid_o), .ready_i(ready_i)
  );

  function automatic int icbrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    return 8'(icbrt(int'(a)) + isqrt(int'(b)));
  endfunction

  // Behavioural fun: latches operands on start, busy for a random number of cycles,
  // result appears on the edge busy drops.
  int         fun_lat_min = 1;
  int         fun_lat_max = 4;
  int         fun_cnt = 0;
  logic [7:0] fa = 8'h00;
  logic [7:0] fb = 8'h00;
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      busy_i  <= 1'b0;
      res_i   <= 8'h00;
      fun_cnt <= 0;
    end else if (busy_i) begin
      if (fun_cnt == 0) begin
        busy_i <= 1'b0;
        res_i  <= ref_y(fa, fb);
      end else begin
        fun_cnt <= fun_cnt - 1;
      end
    end else if (start_o) begin
      busy_i  <= 1'b1;
      fa      <= a_bo;
      fb      <= b_bo;
      fun_cnt <= int'($urandom_range(fun_lat_max - 1, fun_lat_min - 1));
    end
  end

  // Reference model: occupancy, job outstanding, overflow, expected dispatch and results.
  int          mcount = 0;
  bit          outst = 1'b0;
  bit          movf = 1'b0;
  bit          exp_start = 1'b0;
  logic [7:0]  exp_a = 8'h00;
  logic [7:0]  exp_b = 8'h00;
  logic [7:0]  exp_q[$];
  logic [15:0] op_q[$];
  always @(posedge clk or negedge rst_i) begin : model
    bit          pop_p;
    bit          acc;
    logic [15:0] op;
    if (!rst_i) begin
      mcount = 0; outst = 1'b0; movf = 1'b0; exp_start = 1'b0;
      exp_a = 8'h00; exp_b = 8'h00;
      exp_q.delete(); op_q.delete();
    end else begin
      pop_p = !outst && (mcount > 0);
      if (valid_o && ready_i) outst = 1'b0;
      if (pop_p) begin
        op = op_q.pop_front();
        exp_a = op[15:8];
        exp_b = op[7:0];
        outst = 1'b1;
      end
      acc = push_i && ((mcount < DEPTH) || pop_p);
      if (push_i && !acc) movf = 1'b1;
      if (acc) begin
        op_q.push_back({a_i, b_i});
        exp_q.push_back(ref_y(a_i, b_i));
      end
      mcount    = mcount + int'(acc) - int'(pop_p);
      exp_start = pop_p;
    end
  end

  // Output monitor: pops the scoreboard on each handshake, checks result hold stability.
  int         n_results = 0;
  bit         hold_prev = 1'b0;
  logic [7:0] y_prev = 8'h00;
  always @(posedge clk) begin : monitor
    logic [7:0] want;
    if (!rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!valid_o || y_bo !== y_prev) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b y=%0d, want valid=1 y=%0d", valid_o, y_bo, y_prev);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        n_results++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_order: got y=%0d, want no result pending", y_bo);
        end else begin
          want = exp_q.pop_front();
          if (y_bo !== want) begin
            errors++;
            $display("FAIL result_order: got y=%0d, want %0d", y_bo, want);
          end
        end
      end
      hold_prev = valid_o && !ready_i;
      y_prev    = y_bo;
    end
  end

  // Per-cycle status comparison against the reference model.
  always @(negedge clk) begin
    if (rst_i) begin
      checks++;
      if (count_o !== CW'(mcount) || full_o !== (mcount == DEPTH) || ovf_o !== movf ||
          start_o !== exp_start || a_bo !== exp_a || b_bo !== exp_b) begin
        errors++;
        $display("FAIL status: got cnt=%0d full=%0b ovf=%0b start=%0b a=%0d b=%0d, want cnt=%0d full=%0b ovf=%0b start=%0b a=%0d b=%0d",
                 count_o, full_o, ovf_o, start_o, a_bo, b_bo,
                 mcount, (mcount == DEPTH), movf, exp_start, exp_a, exp_b);
      end
      if (start_o && busy_i) begin
        checks++;
        errors++;
        $display("FAIL start_while_busy: got start=1 busy=1, want no start while busy");
      end
    end
  end

  task automatic check_val(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({y_bo, valid_o, start_o, a_bo, b_bo, ovf_o, count_o, full_o} !== '0) begin
      errors++;
      $display("FAIL %s: got y=%0d valid=%0b start=%0b a=%0d b=%0d ovf=%0b cnt=%0d full=%0b, want all 0",
               nm, y_bo, valid_o, start_o, a_bo, b_bo, ovf_o, count_o, full_o);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    push_i = 1'b1; a_i = a; b_i = b;
    @(negedge clk);
    push_i = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int max);
    int n = 0;
    while (!valid_o && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: got no valid within %0d cycles, want valid", nm, max);
    end
  endtask

  task automatic accept();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic drain(input string nm, input int max);
    int n = 0;
    ready_i = 1'b1;
    push_i  = 1'b0;
    while ((mcount > 0 || outst) && n < max) begin
      @(negedge clk);
      n++;
    end
    ready_i = 1'b0;
    if (mcount > 0 || outst) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d queued after %0d cycles, want 0", nm, mcount, max);
    end
  endtask

  initial begin
    int base;
    logic [7:0] y_hold;
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_i = 1'b1;
    @(negedge clk);

    // single job
    push(8'd27, 8'd16);
    wait_valid("single_valid", 50);
    check_val("single_y", int'(y_bo), 7);
    accept();
    repeat (2) @(negedge clk);
    check_val("single_count", int'(count_o), 0);

    // boundary operands, order preserved
    push(8'd0, 8'd0);
    push(8'd255, 8'd255);
    wait_valid("bound_valid0", 50);
    check_val("bound_y0", int'(y_bo), 0);
    accept();
    wait_valid("bound_valid1", 50);
    check_val("bound_y1", int'(y_bo), 21);
    accept();
    drain("bound_drain", 50);

    // fill and overflow: 6 back-to-back pushes with downstream stalled
    base = n_results;
    for (int i = 0; i < 6; i++) push(8'(10 * i + 1), 8'(20 * i + 3));
    check_val("fill_full", int'(full_o), 1);
    check_val("fill_ovf", int'(ovf_o), 1);
    check_val("fill_count", int'(count_o), 4);
    drain("fill_drain", 300);
    repeat (5) @(negedge clk);
    check_val("fill_results", n_results - base, 5);

    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // push/pop collision with FIFO full and FSM returning to IDLE
    for (int i = 0; i < 5; i++) push(8'(50 + i), 8'(100 + i));
    wait_valid("coll_valid", 50);
    check_val("coll_pre_count", int'(count_o), 4);
    accept();
    push(8'd125, 8'd144);
    check_val("coll_count", int'(count_o), 4);
    check_val("coll_ovf", int'(ovf_o), 0);

    // backpressure: result held for 10 cycles with entries queued
    wait_valid("bp_valid", 50);
    y_hold = y_bo;
    repeat (10) @(negedge clk);
    check_val("bp_y_stable", int'(y_bo), int'(y_hold));
    check_val("bp_valid_stable", int'(valid_o), 1);
    drain("bp_drain", 300);

    // randomized traffic
    fun_lat_max = 6;
    for (int c = 0; c < 1500; c++) begin
      push_i  = ($urandom_range(99, 0) < 40);
      a_i     = 8'($urandom_range(255, 0));
      b_i     = 8'($urandom_range(255, 0));
      ready_i = ($urandom_range(99, 0) < 60);
      @(negedge clk);
    end
    drain("rand_drain", 500);

    // asynchronous reset while the job is in WAIT
    fun_lat_min = 6;
    fun_lat_max = 8;
    push(8'd100, 8'd100);
    begin
      int n = 0;
      while (!start_o && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_val("rw_start_seen", int'(start_o), 1);
    end
    @(negedge clk);
    #2 rst_i = 1'b0;
    #1 check_zero("reset_mid_wait");
    @(negedge clk);
    rst_i = 1'b1;
    fun_lat_min = 1;
    fun_lat_max = 4;
    @(negedge clk);
    push(8'd8, 8'd9);
    wait_valid("rw_valid", 50);
    check_val("rw_y", int'(y_bo), 5);
    accept();
    drain("final_drain", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
